// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake, one-byte skid register, 8-N-1 frame LSB first.
// Define UART_TX_PARITY_EN to insert a parity bit (sense chosen by PARITY_ODD), giving 8-P-1.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_ODD   = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_byte_rdy,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_ready,
  output logic       o_tx,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be in 2..65535");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             full_q, full_d;
  logic             tx_q, tx_d;
  logic             baud_last;
  logic             load;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign baud_last = (baud_q == BAUD_LAST);

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    full_d  = full_q;
    load    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (full_q) begin
          load    = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) state_d = S_DATA;
      end
      S_DATA: begin
        if (baud_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (baud_last) begin
          // A waiting byte starts its frame on the very next cycle: no idle gap.
          if (full_q) begin
            load    = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE) baud_d = baud_last ? '0 : baud_q + CNT_W'(1);

    if (load) begin
      shift_d = hold_q;
      full_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = (^hold_q) ^ (PARITY_ODD != 0);
`endif
    end

    // Drain and accept are exclusive: accept needs the holding register empty.
    if (i_tx_byte_rdy && !full_q) begin
      hold_d = i_tx_byte;
      full_d = 1'b1;
    end

    // The line register follows the next state so o_tx lines up with state_q.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign o_tx       = tx_q;
  assign o_tx_ready = !full_q;
  assign o_tx_busy  = (state_q != S_IDLE);
  assign o_tx_done  = (state_q == S_STOP) && baud_last;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: cycle-exact line monitor fed by a byte scoreboard,
// plus per-scenario tasks for reset, handshake timing, back-to-back, mid-frame reset and minimum baud.
module tb_uart_tx;

  localparam int CPB_A = 4;
  localparam int CPB_B = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       a_rdy, b_rdy;
  logic [7:0] a_byte, b_byte;
  logic       a_ready, a_tx, a_busy, a_done;
  logic       b_ready, b_tx, b_busy, b_done;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB_A), .PARITY_ODD(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_tx_byte_rdy(a_rdy), .i_tx_byte(a_byte),
    .o_tx_ready(a_ready), .o_tx(a_tx), .o_tx_busy(a_busy), .o_tx_done(a_done)
  );

  uart_tx #(.CLKS_PER_BIT(CPB_B), .PARITY_ODD(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_tx_byte_rdy(b_rdy), .i_tx_byte(b_byte),
    .o_tx_ready(b_ready), .o_tx(b_tx), .o_tx_busy(b_busy), .o_tx_done(b_done)
  );

  // Line level for each bit slot: start, 8 data LSB first, optional parity, stop(s).
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit odd);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9] = (^d) ^ odd;
`endif
    return f;
  endfunction

  // Monitor on dut_a: every frame must match the oldest scoreboard byte cycle by cycle.
  initial begin : monitor
    logic        prev;
    logic [7:0]  exp_byte;
    logic [10:0] f;
    bit          ok, aborted;
    int          bad_c;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && !a_tx) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL monitor_unexpected_frame: start bit seen with empty scoreboard");
        end else begin
          exp_byte = sb_q.pop_front();
          f        = frame_bits(exp_byte, 1'b0);
          ok       = 1'b1;
          aborted  = 1'b0;
          bad_c    = -1;
          for (int c = 0; c < NBITS * CPB_A; c++) begin
            if (c > 0) @(negedge clk);
            if (rst) begin
              aborted = 1'b1;
              break;
            end
            if (a_tx !== f[c / CPB_A] || a_busy !== 1'b1 ||
                a_done !== (c == NBITS * CPB_A - 1)) begin
              if (ok) bad_c = c;
              ok = 1'b0;
            end
          end
          if (!aborted) begin
            checks++;
            if (!ok) begin
              failures++;
              $display("FAIL monitor_frame: byte %h first wrong at frame cycle %0d (tx/busy/done vs model)",
                       exp_byte, bad_c);
            end
          end
        end
      end
      prev = a_tx;
    end
  end

  task automatic test_reset();
    rst = 1'b1; a_rdy = 1'b0; b_rdy = 1'b0; a_byte = '0; b_byte = '0;
    repeat (2) @(negedge clk);
    checks++; if (a_tx !== 1'b1)    begin failures++; $display("FAIL reset_tx: got %b want 1", a_tx); end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", a_ready); end
    checks++; if (a_busy !== 1'b0)  begin failures++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    checks++; if (a_done !== 1'b0)  begin failures++; $display("FAIL reset_done: got %b want 0", a_done); end
    checks++; if (b_tx !== 1'b1)    begin failures++; $display("FAIL reset_tx_b: got %b want 1", b_tx); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame();
    int cyc, busy_cnt, done_cyc, done_cnt;
    @(negedge clk); a_byte = 8'h55; a_rdy = 1'b1; sb_q.push_back(8'h55);
    @(negedge clk); a_rdy = 1'b0;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL single_ready_n1: got %b want 0", a_ready); end
    @(negedge clk);
    checks++; if (a_tx !== 1'b0)    begin failures++; $display("FAIL single_start_n2: got %b want 0", a_tx); end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL single_ready_n2: got %b want 1", a_ready); end
    cyc = 2; busy_cnt = a_busy ? 1 : 0; done_cyc = -1; done_cnt = 0;
    while (a_busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (a_done) begin done_cnt++; done_cyc = cyc; end
      if (a_busy) busy_cnt++;
    end
    checks++; if (done_cyc != NBITS * CPB_A + 1) begin failures++; $display("FAIL single_done_cycle: got N+%0d want N+%0d", done_cyc, NBITS * CPB_A + 1); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL single_done_count: got %0d want 1", done_cnt); end
    checks++; if (busy_cnt != NBITS * CPB_A) begin failures++; $display("FAIL single_busy_len: got %0d want %0d", busy_cnt, NBITS * CPB_A); end
  endtask

  task automatic test_back_to_back();
    int w;
    bit early;
    @(negedge clk); a_byte = 8'hA3; a_rdy = 1'b1; sb_q.push_back(8'hA3);
    @(negedge clk); a_rdy = 1'b0;
    w = 0;
    while (!a_ready && w < 10) begin @(negedge clk); w++; end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_rise: got %b want 1", a_ready); end
    a_byte = 8'h0F; a_rdy = 1'b1; sb_q.push_back(8'h0F);
    @(negedge clk); a_byte = 8'h77; a_rdy = 1'b1;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL b2b_holding_full: got %b want 0", a_ready); end
    early = 1'b0; w = 0;
    while (!a_done && w < 200) begin
      @(negedge clk);
      w++;
      if (a_ready) early = 1'b1;
    end
    checks++; if (a_done !== 1'b1) begin failures++; $display("FAIL b2b_first_done: got %b want 1", a_done); end
    checks++; if (early) begin failures++; $display("FAIL b2b_0x77_blocked: ready went 1 want 0 until drain"); end
    @(negedge clk);
    checks++; if (a_tx !== 1'b0)    begin failures++; $display("FAIL b2b_zero_gap: got %b want 0", a_tx); end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_drain: got %b want 1", a_ready); end
    sb_q.push_back(8'h77);
    @(negedge clk); a_rdy = 1'b0;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL b2b_0x77_taken: got %b want 0", a_ready); end
    w = 0;
    while (a_busy && w < 300) begin @(negedge clk); w++; end
    repeat (2) @(negedge clk);
    checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL b2b_scoreboard_drained: got %0d left want 0", sb_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int w, done_cnt;
    bit started;
    @(negedge clk); a_byte = 8'hC6; a_rdy = 1'b1; sb_q.push_back(8'hC6);
    @(negedge clk); a_rdy = 1'b0;
    repeat (18) @(negedge clk);
    checks++; if (a_tx !== 1'b0) begin failures++; $display("FAIL mid_bit3_value: got %b want 0", a_tx); end
    #2 rst = 1'b1;
    #1;
    checks++; if (a_tx !== 1'b1)    begin failures++; $display("FAIL mid_rst_tx: got %b want 1", a_tx); end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready: got %b want 1", a_ready); end
    checks++; if (a_busy !== 1'b0)  begin failures++; $display("FAIL mid_rst_busy: got %b want 0", a_busy); end
    checks++; if (a_done !== 1'b0)  begin failures++; $display("FAIL mid_rst_done: got %b want 0", a_done); end
    sb_q.delete();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); a_byte = 8'h81; a_rdy = 1'b1; sb_q.push_back(8'h81);
    @(negedge clk); a_rdy = 1'b0;
    w = 0; done_cnt = 0; started = 1'b0;
    while (!(started && !a_busy) && w < 100) begin
      @(negedge clk);
      w++;
      if (a_busy) started = 1'b1;
      if (a_done) done_cnt++;
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL mid_after_done_count: got %0d want 1", done_cnt); end
    checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL mid_after_scoreboard: got %0d left want 0", sb_q.size()); end
  endtask

  task automatic capture_b(input logic [7:0] d, output logic [21:0] line,
                           output int done_at, output int done_n, output int busy_n);
    @(negedge clk); b_byte = d; b_rdy = 1'b1;
    @(negedge clk); b_rdy = 1'b0;
    line = '0; done_at = -1; done_n = 0; busy_n = 0;
    for (int c = 0; c < NBITS * CPB_B; c++) begin
      @(negedge clk);
      line[c] = b_tx;
      if (b_done) begin done_n++; done_at = c; end
      if (b_busy) busy_n++;
    end
  endtask

  task automatic test_min_baud();
    logic [21:0] line, exp_line;
    logic [10:0] f;
    int done_at, done_n, busy_n;
    f = frame_bits(8'hFF, 1'b1);
    exp_line = '0;
    for (int c = 0; c < NBITS * CPB_B; c++) exp_line[c] = f[c / CPB_B];
    capture_b(8'hFF, line, done_at, done_n, busy_n);
    checks++; if (line !== exp_line) begin failures++; $display("FAIL minbaud_line: got %b want %b", line, exp_line); end
    checks++; if (done_at != NBITS * CPB_B - 1) begin failures++; $display("FAIL minbaud_done_at: got %0d want %0d", done_at, NBITS * CPB_B - 1); end
    checks++; if (done_n != 1) begin failures++; $display("FAIL minbaud_done_count: got %0d want 1", done_n); end
    checks++; if (busy_n != NBITS * CPB_B) begin failures++; $display("FAIL minbaud_busy_len: got %0d want %0d", busy_n, NBITS * CPB_B); end
    @(negedge clk);
    checks++; if (b_busy !== 1'b0 || b_tx !== 1'b1 || b_ready !== 1'b1) begin
      failures++; $display("FAIL minbaud_idle_after: busy=%b tx=%b ready=%b want 0 1 1", b_busy, b_tx, b_ready);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [21:0] line;
    int done_at, done_n, busy_n, w;
    @(negedge clk); a_byte = 8'h07; a_rdy = 1'b1; sb_q.push_back(8'h07);
    @(negedge clk); a_rdy = 1'b0;
    repeat (37) @(negedge clk);
    checks++; if (a_tx !== 1'b1) begin failures++; $display("FAIL parity_even_bit: got %b want 1", a_tx); end
    w = 0;
    while (a_busy && w < 100) begin @(negedge clk); w++; end
    capture_b(8'h07, line, done_at, done_n, busy_n);
    checks++; if (line[18] !== 1'b0 || line[19] !== 1'b0) begin
      failures++; $display("FAIL parity_odd_bit: got %b%b want 00", line[19], line[18]);
    end
    checks++; if (done_at != 21) begin failures++; $display("FAIL parity_odd_done_at: got %0d want 21", done_at); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_min_baud();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
